// File: rtl/twos_pkg.sv
// rtl/twos_pkg.sv - shared width default, FSM encoding and counter sizing for the serial decoder
package twos_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder used as the serial bit cell
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Carry
);

    assign Y     = A ^ B ^ Cin;
    assign Carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/twos_decode_serial.sv
// rtl/twos_decode_serial.sv - bit-serial two's-complement to sign-magnitude decoder
module twos_decode_serial
    import twos_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] mag;
    logic             sign_q;
    logic             carry;
    logic             sign_out_q;
    logic             accept;
    logic             last_bit;
    logic             fa_a;
    logic             fa_sum;
    logic             fa_cout;

    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out_sign  = sign_out_q;
    assign out_mag   = mag;
    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

    // |x| = (x ^ sign) + sign, evaluated one bit per cycle with the carry seeded by the sign
    assign fa_a = operand[0] ^ sign_q;

    fulladder u_bit_cell (
        .A     (fa_a),
        .B     (1'b0),
        .Cin   (carry),
        .Y     (fa_sum),
        .Carry (fa_cout)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            operand    <= '0;
            mag        <= '0;
            sign_q     <= 1'b0;
            carry      <= 1'b0;
            sign_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        operand <= in_data;
                        sign_q  <= in_data[WIDTH-1];
                        carry   <= in_data[WIDTH-1];
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // sum enters at the MSB so bit i settles at position i after WIDTH shifts
                    operand <= operand >> 1;
                    mag     <= {fa_sum, mag[WIDTH-1:1]};
                    carry   <= fa_cout;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last_bit) begin
                        sign_out_q <= sign_q;
                        bit_cnt    <= '0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twos_decode_serial.sv
// tb/tb_twos_decode_serial.sv - self-checking bench for twos_decode_serial
module tb_twos_decode_serial;

    localparam int W = 8;

    typedef struct {
        bit         s;
        logic [7:0] m;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit   m_busy  = 1'b0;
    bit   m_valid = 1'b0;
    int   m_cnt   = 0;
    res_t pend;
    res_t obs[$];

    always #5 clk = ~clk;

    twos_decode_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag)
    );

    function automatic res_t ref_decode(input logic [7:0] d);
        int   v;
        res_t r;
        v   = int'($signed(d));
        r.s = (v < 0);
        r.m = 8'(v < 0 ? -v : v);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a word is either absent, being decoded for W cycles, or presented
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_cnt  = W;
            pend   = ref_decode(in_data);
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !reset});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid && out_valid) begin
            chk("out_sign", {31'd0, out_sign}, {31'd0, pend.s});
            chk("out_mag", {24'd0, out_mag}, {24'd0, pend.m});
        end
        if (out_valid && out_ready) obs.push_back('{s: out_sign, m: out_mag});
    end

    task automatic wait_accept(output int t);
        bit got;
        got = 1'b0;
        t   = -1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (in_ready && in_valid) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance expected one (cycle %0d)", cyc);
        end
    endtask

    task automatic run_word(input logic [7:0] d, input bit es, input logic [7:0] em,
                            input int hold, input bit dup);
        int t;
        bit got;
        @(posedge clk); #1;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_accept(t);
        @(posedge clk); #1;
        if (dup) in_data = 8'h11;
        else     in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk("latency", cyc - t, W + 1);
        chk("lit_sign", {31'd0, out_sign}, {31'd0, es});
        chk("lit_mag", {24'd0, out_mag}, {24'd0, em});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sign", {31'd0, out_sign}, {31'd0, es});
            chk("hold_mag", {24'd0, out_mag}, {24'd0, em});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ready_rise", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int   t;
        int   t1;
        int   t2;
        res_t r;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        r = ref_decode(8'hFB);
        chk("model_FB", {23'd0, r.s, r.m}, {23'd0, 1'b1, 8'h05});
        r = ref_decode(8'h80);
        chk("model_80", {23'd0, r.s, r.m}, {23'd0, 1'b1, 8'h80});
        r = ref_decode(8'h00);
        chk("model_00", {23'd0, r.s, r.m}, {23'd0, 1'b0, 8'h00});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sign", {31'd0, out_sign}, 32'd0);
        chk("rst_mag", {24'd0, out_mag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_word(8'hFB, 1'b1, 8'h05, 0, 1'b0);
        run_word(8'h80, 1'b1, 8'h80, 0, 1'b0);
        run_word(8'h00, 1'b0, 8'h00, 0, 1'b0);
        run_word(8'h7F, 1'b0, 8'h7F, 5, 1'b1);

        // abort a word mid-decode with a one-cycle reset at T+4
        @(posedge clk); #1;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        wait_accept(t);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("abort_cycle", cyc - t, 4);
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_mag", {24'd0, out_mag}, 32'd0);
        chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
        run_word(8'hFF, 1'b1, 8'h01, 0, 1'b0);

        // back-to-back offer: second word waits for the first handshake
        obs.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_data   = 8'h01;
        in_valid  = 1'b1;
        wait_accept(t1);
        @(posedge clk); #1;
        in_data = 8'hFE;
        wait_accept(t2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 30 && obs.size() < 2; k++) @(negedge clk);
        chk("b2b_gap", t2 - t1, W + 2);
        chk("b2b_count", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("b2b_first", {23'd0, obs[0].s, obs[0].m}, {23'd0, 1'b0, 8'h01});
            chk("b2b_second", {23'd0, obs[1].s, obs[1].m}, {23'd0, 1'b1, 8'h02});
        end

        // exhaustive sweep, checked cycle by cycle against the model
        obs.delete();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            in_data  = 8'(i);
            in_valid = 1'b1;
            wait_accept(t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 30 && obs.size() < 256; k++) @(negedge clk);
        chk("sweep_count", obs.size(), 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/twos_decode_serial.md
TWOS_DECODE_SERIAL -- requirements
Module: twos_decode_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the two's-complement input width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 SHALL have port in_data, input, WIDTH bits: the two's-complement operand.
REQ-007 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-009 SHALL have port out_sign, output, 1 bit: the sign of the result (1 = negative).
REQ-010 SHALL have port out_mag, output, WIDTH bits: the unsigned magnitude of the result.

Function
REQ-011 SHALL decode in_data into sign-magnitude form: out_sign = in_data[WIDTH-1]; out_mag = |in_data| as unsigned WIDTH bits.
REQ-012 SHALL use an FSM with states IDLE, SHIFT and DONE, with the following transitions:
- IDLE->SHIFT on in_valid && in_ready.
- SHIFT->DONE after WIDTH SHIFT cycles.
- DONE->IDLE on out_valid && out_ready.
REQ-013 SHALL drive in_ready = 1 only in IDLE; in_valid in SHIFT or DONE SHALL be ignored and no data captured.
REQ-014 SHALL, on acceptance in cycle T, latch in_data into an operand shift register and latch the sign bit.
REQ-015 SHALL process one bit per SHIFT cycle, LSB first (bit i in cycle T+1+i), using one full-adder bit cell:
- A = operand bit XOR sign.
- B = 0.
- Cin = carry flop.
- Carry flop is initialised to sign at acceptance.
- The sum is shifted into the magnitude register MSB-first so bit i lands at position i after WIDTH shifts.
REQ-016 SHALL assert out_valid in cycle T+WIDTH+1 (latency WIDTH+1 from acceptance), with out_sign/out_mag updated in the same cycle.
REQ-017 SHALL hold out_valid, out_sign and out_mag stable while out_valid && !out_ready.
REQ-018 SHALL deassert out_valid in the cycle after the out_valid && out_ready handshake; in_ready rises in that same cycle.
REQ-019 SHALL map the most negative input (1 followed by WIDTH-1 zeros) to out_sign = 1 and out_mag = 2^(WIDTH-1); no overflow flag exists.
REQ-020 SHALL map input zero to out_sign = 0 and out_mag = 0.
REQ-021 SHALL give one-accept-per-WIDTH+2 cycles minimum throughput; no pipelining of a second word during SHIFT.
REQ-022 SHALL discard the final carry out of the bit cell.

Reset
REQ-023 SHALL, while reset = 1, force the following on the next edge regardless of state (including mid-SHIFT or DONE), aborting any in-flight word:
- FSM = IDLE.
- Bit counter = 0.
- Carry = 0.
- Operand/magnitude registers = 0.
- out_valid = 0, out_sign = 0, out_mag = 0.
REQ-024 SHALL drive in_ready = 0 during the reset cycle and 1 in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place WIDTH default, the state encoding (IDLE/SHIFT/DONE) and the bit-counter width ($clog2(WIDTH+1)) in the shared package twos_pkg.
REQ-026 SHALL instantiate exactly one fulladder sub-module (ports A, B, Cin, Y, Carry) as the serial bit cell; no per-bit adder chain.

Verification
REQ-027 SHALL cover: accept 8'hFB (-5), out_ready = 1 -> out_valid at T+9, out_sign = 1, out_mag = 8'h05.
REQ-028 SHALL cover: accept 8'h80 -> out_sign = 1, out_mag = 8'h80; accept 8'h00 -> out_sign = 0, out_mag = 8'h00.
REQ-029 SHALL cover: accept 8'h7F, out_ready held 0 for 5 cycles -> out_valid/out_mag = 8'h7F stable, in_ready = 0 throughout, second in_valid ignored.
REQ-030 SHALL cover: reset asserted at T+4 mid-SHIFT -> next cycle out_valid = 0, out_mag = 0; in_ready = 1 after release; a fresh word 8'hFF decodes to sign 1, mag 8'h01.
REQ-031 SHALL cover: back-to-back in_valid with 8'h01 then 8'hFE -> second accepted only after the first handshake; results (0,1) then (1,2).
REQ-032 SHALL cover an exhaustive sweep of all 256 inputs compared against a reference model.
